// File: rtl/pairing_host_port_if.sv
// pairing_host_port_if: command/response bus and serial core port of the pairing host master
interface pairing_host_port_if #(parameter int W = 198, parameter int AW = 6);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_data;
  logic          resp_valid;
  logic [W-1:0]  resp_data;
  logic          busy;
  logic          sel;
  logic [AW-1:0] addr;
  logic          update;
  logic          ready;
  logic          i;
  logic          w;
  logic          o;
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, o,
    input  cmd_ready, resp_valid, resp_data, busy, sel, addr, update, ready, i, w
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, o,
    output cmd_ready, resp_valid, resp_data, busy, sel, addr, update, ready, i, w
  );
endinterface

// File: rtl/pairing_host_port.sv
// pairing_host_port: word-parallel command to bit-serial core port sequencer
module pairing_host_port #(
  parameter int W  = 198,
  parameter int AW = 6,
  parameter int CW = 8
) (
  input logic clk,
  input logic reset,
  pairing_host_port_if.slave bus
);
  typedef enum logic [2:0] {IDLE, W_UPD, W_SH, W_CMT, R_SET, R_UPD, R_SH, R_RSP} state_t;
  state_t        state;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          last;
  assign last     = cnt == CW'(W - 1);
  assign bus.busy = ~bus.cmd_ready;
  // sequencer; every core-side output is registered alongside the state it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sr             <= '0;
      cnt            <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.sel        <= 1'b0;
      bus.addr       <= '0;
      bus.update     <= 1'b0;
      bus.ready      <= 1'b0;
      bus.i          <= 1'b0;
      bus.w          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
          bus.addr      <= bus.cmd_addr;
          sr            <= bus.cmd_data;
          bus.sel       <= 1'b1;
          bus.cmd_ready <= 1'b0;
          bus.update    <= bus.cmd_write;
          state         <= bus.cmd_write ? W_UPD : R_SET;
        end
        W_UPD: begin
          bus.update <= 1'b0;
          bus.ready  <= 1'b1;
          bus.i      <= sr[0];
          cnt        <= '0;
          state      <= W_SH;
        end
        W_SH: begin
          sr  <= sr >> 1;
          cnt <= last ? cnt : cnt + CW'(1);
          if (last) begin
            bus.ready <= 1'b0;
            bus.i     <= 1'b0;
            bus.w     <= 1'b1;
            state     <= W_CMT;
          end else bus.i <= sr[1];
        end
        W_CMT: begin
          bus.w         <= 1'b0;
          bus.sel       <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        R_SET: begin
          bus.update <= 1'b1;
          state      <= R_UPD;
        end
        R_UPD: begin
          bus.update <= 1'b0;
          bus.ready  <= 1'b1;
          cnt        <= '0;
          state      <= R_SH;
        end
        R_SH: begin
          sr  <= {bus.o, sr[W-1:1]};
          cnt <= last ? cnt : cnt + CW'(1);
          if (last) begin
            bus.ready      <= 1'b0;
            bus.resp_data  <= {bus.o, sr[W-1:1]};
            bus.resp_valid <= 1'b1;
            state          <= R_RSP;
          end
        end
        R_RSP: begin
          bus.resp_valid <= 1'b0;
          bus.sel        <= 1'b0;
          bus.cmd_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pairing_host_port.sv
// tb_pairing_host_port: randomized self-checking bench with a word-level core model and shadow memory
module tb_pairing_host_port;
  localparam int W  = 198;
  localparam int AW = 6;
  localparam logic [W-1:0] K_WR = 198'h288162298554054820552a05426081a1842886a58916a6249;
  localparam logic [W-1:0] K_RD = 198'h0580908654985206a92415296589411858a9211984160a180;
  localparam logic [W-1:0] K_RT = 198'h2895955069089214054596a189a4420556589054140941695;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_upd = 0, n_w = 0, n_rv = 0;
  logic [W-1:0] shadow [64];
  logic [W-1:0] mem [64];
  logic [W-1:0] cs = '0;
  pairing_host_port_if #(.W(W), .AW(AW)) bus ();
  pairing_host_port #(.W(W), .AW(AW), .CW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.o = cs[0];

  function automatic logic [W-1:0] init_word(input int a);
    logic [W-1:0] v = '0;
    if (a == 9) return K_RD;
    for (int k = 0; k < 7; k++) v = {v[W-33:0], 32'(32'h9E3779B9 * (a * 8 + k + 1))};
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v = '0;
    for (int k = 0; k < 7; k++) v = {v[W-33:0], 32'($urandom())};
    return v;
  endfunction

  // behavioural core: update loads the word, ready shifts o out / i in, w commits it
  initial begin
    for (int a = 0; a < 64; a++) mem[a] = init_word(a);
    forever begin
      @(posedge clk);
      if (bus.update) cs <= mem[bus.addr];
      else if (bus.ready) cs <= {bus.i, cs[W-1:1]};
      if (bus.w) mem[bus.addr] <= cs;
    end
  end

  // event counters sampled on the active edge
  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) n_acc <= n_acc + 1;
    if (bus.update) n_upd <= n_upd + 1;
    if (bus.w) n_w <= n_w + 1;
    if (bus.resp_valid) n_rv <= n_rv + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d, output int waitc);
    waitc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.cmd_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, output int waitc);
    logic [W-1:0] got_i = '0;
    int nr = 0, rbad = 0, ubad = 0, abad = 0, nw = 0, wcyc = 0;
    issue(1'b1, a, d, waitc);
    for (int c = 1; c <= W + 3; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= W + 2 && bus.addr !== a) abad++;
      if (c == 1) check("w_update_c1", W'(bus.update), 1);
      else if (bus.update) ubad++;
      if (bus.ready) begin
        if (nr < W) got_i[nr] = bus.i;
        nr++;
        if (c < 2 || c > W + 1) rbad++;
      end
      if (bus.w) begin
        nw++;
        wcyc = c;
      end
      if (c == W + 3) check("w_end_sel_ready", W'({bus.sel, bus.cmd_ready}), 1);
    end
    check("w_ready_count", W'(nr), W'(W));
    check("w_ready_window", W'(rbad + ubad), 0);
    check("w_serial_data", got_i, d);
    check("w_pulse_count", W'(nw), 1);
    check("w_pulse_cycle", W'(wcyc), W'(W + 2));
    check("w_addr_stable", W'(abad), 0);
    shadow[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int waitc);
    int nr = 0, rbad = 0, nv = 0;
    issue(1'b0, a, '0, waitc);
    for (int c = 1; c <= W + 4; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) check("r_setup", W'({bus.sel, bus.update, bus.ready}), 3'b100);
      if (c == 2) check("r_update_c2", W'(bus.update), 1);
      if (bus.ready) begin
        nr++;
        if (c < 3 || c > W + 2) rbad++;
      end
      if (bus.resp_valid) begin
        nv++;
        check("r_valid_cycle", W'(c), W'(W + 3));
        check("r_data", bus.resp_data, shadow[a]);
      end
      if (c == W + 4) check("r_end_sel_ready", W'({bus.sel, bus.cmd_ready}), 1);
    end
    check("r_ready_count", W'(nr), W'(W));
    check("r_ready_window", W'(rbad), 0);
    check("r_valid_count", W'(nv), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, W'({bus.sel, bus.update, bus.ready, bus.i, bus.w, bus.resp_valid}), 0);
    check({tag, "_addr"}, W'(bus.addr), 0);
    check({tag, "_resp_data"}, bus.resp_data, 0);
    check({tag, "_ready_busy"}, W'({bus.cmd_ready, bus.busy}), 2'b10);
  endtask

  initial begin
    int wc, cnt, a0, w0, u0, r0;
    logic [W-1:0] da, db;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    for (int a = 0; a < 64; a++) shadow[a] = init_word(a);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    do_write(6'd3, K_WR, wc);
    do_read(6'd9, wc);
    do_write(6'd7, K_RT, wc);
    do_read(6'd7, wc);
    check("b2b_wait", W'(wc), 0);
    check("rt_data", bus.resp_data, K_RT);
    da = rnd_word();
    db = rnd_word();
    a0 = n_acc; w0 = n_w; u0 = n_upd;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 6'd20;
    bus.cmd_data  = da;
    @(negedge clk);
    bus.cmd_addr = 6'd21;
    bus.cmd_data = db;
    cnt = 1;
    while (n_acc - a0 < 2 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    bus.cmd_valid = 1'b0;
    check("busy_second_accept", W'(cnt), W'(W + 4));
    repeat (W + 4) @(negedge clk);
    check("busy_accepts", W'(n_acc - a0), 2);
    check("busy_commits", W'(n_w - w0), 2);
    check("busy_updates", W'(n_upd - u0), 2);
    shadow[20] = da;
    shadow[21] = db;
    do_read(6'd20, wc);
    do_read(6'd21, wc);
    w0 = n_w;
    issue(1'b1, 6'd11, rnd_word(), wc);
    repeat (50) @(negedge clk);
    check("mid_shift_ready", W'(bus.ready), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_write");
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 10) @(negedge clk);
    check("rst_write_no_w", W'(n_w - w0), 0);
    check("rst_write_ready", W'(bus.cmd_ready), 1);
    r0 = n_rv;
    issue(1'b0, 6'd12, '0, wc);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_read");
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 10) @(negedge clk);
    check("rst_read_no_valid", W'(n_rv - r0), 0);
    check("rst_read_data", bus.resp_data, 0);
    do_read(6'd5, wc);
    for (int t = 0; t < 12; t++) begin
      logic [AW-1:0] a = AW'($urandom_range(0, 63));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_write(a, rnd_word(), wc);
      else do_read(a, wc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pairing_host_port.md
# pairing_host_port

Host-side serial master for the pairing core's bit-serial memory access port. It accepts word-parallel read/write commands from a controller (CPU bridge, UART loader, or test harness). For each command it generates the sel/addr/update/ready/i/w sequence the pairing core expects, and collects the core's serial `o` stream back into a parallel word. It sits between the system bus and the pairing core and replaces hand-driven serial loading and unloading of operands (xp, yp, xq, yq) and results (addresses 9–14).

## Interface
Parameters:
- `W`, 198: serial word length in bits; 194-bit field elements are zero-padded in the MSBs.
- `AW`, 6: core address width.
- `CW`, 8: bit-counter width; must satisfy 2^CW > W.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state and outputs immediately.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: block is idle and can accept a command.
- `cmd_write`, input, 1: 1 = write, 0 = read.
- `cmd_addr`, input, AW: core word address.
- `cmd_data`, input, W: write data; ignored for reads.
- `resp_valid`, output, 1: one-cycle pulse; `resp_data` is valid.
- `resp_data`, output, W: last read word; held until the next read completes.
- `busy`, output, 1: a transaction is in progress (inverse of `cmd_ready`).
- `sel`, output, 1: to core; host owns the port.
- `addr`, output, AW: to core; word address.
- `update`, output, 1: to core; load/latch the addressed word.
- `ready`, output, 1: to core; shift enable.
- `i`, output, 1: to core; serial write data.
- `w`, output, 1: to core; commit the shifted word.
- `o`, input, 1: from core; serial read data.

## Operation
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`. At that edge, `cmd_addr` is latched into `addr` and `cmd_data` into the shift register `sr`. `cmd_ready` drops in the next cycle.
- All core-side outputs are registered and decoded from the state. `addr` is held constant for the whole transaction.
- States:
  - IDLE: `sel`=0, `cmd_ready`=1, all strobes 0.
  - W_UPD: `sel`=1, `update`=1.
  - W_SH: `sel`=1, `ready`=1, `i`=`sr[0]`. `sr` shifts right each cycle, LSB first. The counter runs 0..W-1.
  - W_CMT: `sel`=1, `w`=1 for exactly one cycle. Next state is IDLE.
  - R_SET: `sel`=1, `addr` valid, strobes 0. This gives one setup cycle.
  - R_UPD: `sel`=1, `update`=1.
  - R_SH: `sel`=1, `ready`=1. At each edge, `sr <= {o, sr[W-1:1]}`. Bit j of the word is `o` sampled at the end of ready cycle j. The counter runs 0..W-1.
  - R_RSP: `resp_data <= sr`, `resp_valid`=1 for one cycle, `sel`=1. Next state is IDLE.
- Transitions:
  - IDLE→W_UPD or IDLE→R_SET on accept.
  - W_UPD→W_SH and R_SET→R_UPD→R_SH unconditionally.
  - W_SH→W_CMT and R_SH→R_RSP when count==W-1.
- The counter clears on entry to each SH state. It never exceeds W-1.
- Responses have no backpressure; the consumer must take `resp_data` on the `resp_valid` pulse.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `resp_valid`=0, `resp_data`=0, `sel`=`update`=`ready`=`i`=`w`=0, `addr`=0, state IDLE.
- Write: cycles are counted after the accept edge:
  - cycle 1: `update`.
  - cycles 2..W+1: `ready`.
  - cycle W+2: `w`.
  - cycle W+3: `cmd_ready`=1.
  - For W=198, `w` is in cycle 200 and the next accept is possible at the end of cycle 201.
- Read:
  - cycle 1: setup.
  - cycle 2: `update`.
  - cycles 3..W+2: `ready`.
  - cycle W+3: `resp_valid`.
  - cycle W+4: `cmd_ready`=1.
- `cmd_valid` while busy is ignored. It is not queued; the command must be held until `cmd_ready`.
- `cmd_ready` is 0 during R_RSP, so accept and response can never coincide.
- Reset mid-transaction aborts it asynchronously:
  - All strobes drop immediately.
  - No `w` and no `resp_valid` is issued.
  - `resp_data` clears to 0.
  - The core word is left partially shifted; software must rewrite it.
- `sel` falls in the first IDLE cycle, which releases the port to the core.

## Test plan
- Write to addr 3 with data 194'h288162298554054820552a05426081a1842886a58916a6249. Required response:
  - `update` in cycle 1.
  - Exactly 198 `ready` cycles, with `i` equal to bits 0..197 LSB first.
  - A single `w` in cycle 200.
  - `addr`=3 throughout.
  - `sel` low in cycle 201.
- Read addr 9 against a behavioural core model holding 194'h0580908654985206a92415296589411858a9211984160a180. Required response: `resp_valid` in cycle 201, `resp_data` equal to that value, one setup cycle before `update`.
- Round trip: write 194'h2895955069089214054596a189a4420556589054140941695 to addr 7, then read addr 7 back through the model. `resp_data` must match exactly, and the two commands must be back-to-back with the second accepted in cycle 201.
- Busy rejection: hold `cmd_valid` with a second command during a write. It is accepted only once `cmd_ready` rises, and there is no duplicate transaction.
- Reset mid-shift: assert `reset` in ready cycle 50 of a write. All outputs go to 0 within the same cycle, no `w` pulse occurs, and `cmd_ready`=1 after release.
- Reset during a read: assert `reset` in cycle 100. No `resp_valid` occurs and `resp_data`=0. A subsequent read of addr 5 returns the correct word.
